// File: rtl/uart_img_loader_ctrl_pkg.sv
// Shared definitions for the UART image loader: state encodings, protocol bytes and
// the digit-to-ASCII mapping used for the result byte.
package uart_img_loader_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_WAIT_INF = 3'd3;
  localparam logic [2:0] ST_SEND     = 3'd4;
  localparam logic [2:0] ST_WAIT_TXH = 3'd5;
  localparam logic [2:0] ST_WAIT_TXL = 3'd6;

  localparam int unsigned IMG_PIXELS_DEF = 784;
  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hAA;
  localparam logic [7:0]  ASCII_ZERO     = 8'h30;
  localparam logic [7:0]  ASCII_ERR      = 8'h3F;

  // Digits 0..9 map to '0'..'9'; anything else is reported as '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_ERR : ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Saturating idle-cycle counter; expired is high once TIMEOUT_CYC-1 ticks have
// accumulated since the last clear.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned    TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]  LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/uart_img_loader_ctrl.sv
// Sequencer between the UART byte link and the MNIST core: sync-byte framed image
// load into RAM, inference start, and ASCII result return over uart_tx.
module uart_img_loader_ctrl
  import uart_img_loader_ctrl_pkg::*;
#(
  parameter int unsigned IMG_PIXELS  = IMG_PIXELS_DEF,
  parameter int unsigned ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_byte,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [7:0]        img_wdata,
  output logic              infer_start,
  input  logic              infer_done,
  input  logic [3:0]        infer_result,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] cnt;
  logic              tmr_clear;
  logic              tmr_tick;
  logic              tmr_expired;

  // Held clear while idle so every frame starts LOAD with a fresh timer.
  assign tmr_clear = (state == ST_IDLE) || ((state == ST_LOAD) && rx_done);
  assign tmr_tick  = (state == ST_LOAD) && !rx_done;

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (tmr_clear),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (rx_done && (rx_byte == SYNC_BYTE)) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (rx_done) begin
          if (cnt == LAST_PIX) state_nx = ST_START;
        end else if (tmr_expired) begin
          state_nx = ST_IDLE;
        end
      end
      ST_START:    state_nx = ST_WAIT_INF;
      // An idle transmitter lets the result go out directly, skipping SEND.
      ST_WAIT_INF: if (infer_done) state_nx = tx_busy ? ST_SEND : ST_WAIT_TXH;
      ST_SEND:     if (!tx_busy) state_nx = ST_WAIT_TXH;
      ST_WAIT_TXH: if (tx_busy) state_nx = ST_WAIT_TXL;
      ST_WAIT_TXL: if (!tx_busy) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      tx_en       <= 1'b0;
      tx_byte     <= '0;
      img_we      <= 1'b0;
      img_addr    <= '0;
      img_wdata   <= '0;
      infer_start <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != ST_IDLE);
      img_we      <= 1'b0;
      tx_en       <= 1'b0;
      infer_start <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_done && (rx_byte == SYNC_BYTE)) cnt <= '0;
        end
        ST_LOAD: begin
          if (rx_done) begin
            img_we    <= 1'b1;
            img_addr  <= cnt;
            img_wdata <= rx_byte;
            cnt       <= cnt + 1'b1;
          end else if (tmr_expired) begin
            frame_err <= 1'b1;
          end
        end
        ST_START: infer_start <= 1'b1;
        ST_WAIT_INF: begin
          if (infer_done) begin
            tx_byte <= digit_to_ascii(infer_result);
            tx_en   <= !tx_busy;
          end
        end
        ST_SEND: begin
          if (!tx_busy) tx_en <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_img_loader_ctrl.sv
// Self-checking bench for uart_img_loader_ctrl: scoreboard of expected RAM writes,
// start/error strobes and tx bytes derived from a frame-level model of the protocol.
module tb_uart_img_loader_ctrl;

  localparam int unsigned PIX  = 784;
  localparam int unsigned AW   = 10;
  localparam int unsigned TMO  = 1000;
  localparam logic [7:0]  SYNC = 8'hAA;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic          tx_busy;
  logic          tx_en;
  logic [7:0]    tx_byte;
  logic          img_we;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_wdata;
  logic          infer_start;
  logic          infer_done;
  logic [3:0]    infer_result;
  logic          busy;
  logic          frame_err;

  uart_img_loader_ctrl #(
    .IMG_PIXELS (PIX),
    .ADDR_W     (AW),
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_byte     (tx_byte),
    .img_we      (img_we),
    .img_addr    (img_addr),
    .img_wdata   (img_wdata),
    .infer_start (infer_start),
    .infer_done  (infer_done),
    .infer_result(infer_result),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  typedef struct { int addr; int data; int at; } wr_t;
  typedef struct { int val; int at; } ev_t;
  typedef struct { logic [3:0] res; int hold; logic [7:0] exp_b; } vec_t;

  wr_t exp_wr[$];
  int  exp_start[$];
  int  exp_ferr[$];
  ev_t exp_tx[$];

  // Frame-level model: loading a frame, or busy with an inference/reply.
  bit m_loading;
  bit m_infer;
  int m_idx;
  int m_gap;

  int n_we = 0, n_start = 0, n_ferr = 0;
  int tx_en_cyc = -1;

  always @(negedge sys_clk) begin
    if (img_we === 1'b1) begin
      n_we++;
      if (exp_wr.size() == 0) chk("unexpected_img_we", img_we, 0);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("img_addr", img_addr, w.addr);
        chk("img_wdata", img_wdata, w.data);
        chk("img_we_cycle", cyc, w.at);
      end
    end
    if (infer_start === 1'b1) begin
      n_start++;
      if (exp_start.size() == 0) chk("unexpected_infer_start", infer_start, 0);
      else chk("infer_start_cycle", cyc, exp_start.pop_front());
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      if (exp_ferr.size() == 0) chk("unexpected_frame_err", frame_err, 0);
      else chk("frame_err_cycle", cyc, exp_ferr.pop_front());
    end
    if (tx_en === 1'b1) begin
      tx_en_cyc = cyc;
      if (exp_tx.size() == 0) chk("unexpected_tx_en", tx_en, 0);
      else begin
        ev_t e;
        e = exp_tx.pop_front();
        chk("tx_byte", tx_byte, e.val);
        chk("tx_en_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    rx_done    = 1'b0;
    infer_done = 1'b0;
  endtask

  task automatic model_clear();
    m_loading = 0;
    m_infer   = 0;
    m_gap     = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_loading) begin
        m_gap++;
        if (m_gap == TMO) begin
          m_loading = 0;
          exp_ferr.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick();
    rx_done = 1'b1;
    rx_byte = b;
    if (m_loading) begin
      exp_wr.push_back('{m_idx, int'(b), cyc + 1});
      m_idx++;
      m_gap = 0;
      if (m_idx == PIX) begin
        m_loading = 0;
        m_infer   = 1;
        exp_start.push_back(cyc + 2);
      end
    end else if (!m_infer && b == SYNC) begin
      m_loading = 1;
      m_idx     = 0;
      m_gap     = 0;
    end
    idle(gap);
  endtask

  task automatic frame(input int gmin, input int gmax);
    send(SYNC, 1);
    for (int i = 0; i < PIX; i++) send(8'($urandom), int'($urandom_range(gmax, gmin)));
  endtask

  task automatic chk_zero(input string name);
    chk(name, {tx_en, tx_byte, img_we, img_addr, img_wdata, infer_start, busy, frame_err}, 0);
  endtask

  task automatic do_reset(input string name);
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_zero(name);
    model_clear();
  endtask

  // Answers an inference, then plays uart_tx: busy for 100 cycles after tx_en.
  task automatic do_tx(input logic [3:0] res, input int hold, input logic [7:0] exp_b,
                       input bit rst_txh);
    bit done;
    bit stable;
    done   = 0;
    stable = 1;
    idle(3);
    send(SYNC, 2);
    tx_busy   = (hold > 0);
    tx_en_cyc = -1;
    tick();
    infer_done   = 1'b1;
    infer_result = res;
    exp_tx.push_back('{int'(exp_b), (hold == 0) ? cyc + 1 : cyc + hold + 2});
    chk("busy_wait_inf", busy, 1);
    for (int k = 1; k < 400 && !done; k++) begin
      tick();
      if (tx_en_cyc >= 0 && tx_byte !== exp_b) stable = 0;
      if (k <= hold) tx_busy = 1'b1;
      else if (!rst_txh && tx_en_cyc >= 0 && cyc > tx_en_cyc && cyc <= tx_en_cyc + 100)
        tx_busy = 1'b1;
      else tx_busy = 1'b0;
      if (rst_txh && tx_en_cyc >= 0 && cyc == tx_en_cyc + 2) begin
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_zero("reset_in_wait_txh");
        model_clear();
        done = 1;
      end else if (!rst_txh && tx_en_cyc >= 0 && cyc == tx_en_cyc + 101) begin
        @(negedge sys_clk);
        chk("busy_before_txl_exit", busy, 1);
        tick();
        @(negedge sys_clk);
        chk("busy_after_tx_done", busy, 0);
        m_infer = 0;
        done    = 1;
      end
    end
    chk("tx_sequence_in_time", done, 1);
    chk("tx_byte_stable", stable, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int s0;
    int w0;
    vecs[0] = '{4'd7,  0,  8'h37};
    vecs[1] = '{4'd0,  20, 8'h30};
    vecs[2] = '{4'd9,  0,  8'h39};
    vecs[3] = '{4'd10, 0,  8'h3F};
    vecs[4] = '{4'd12, 5,  8'h3F};
    vecs[5] = '{4'd15, 0,  8'h3F};

    sys_rst = 1'b1; rx_done = 1'b0; rx_byte = '0; tx_busy = 1'b0;
    infer_done = 1'b0; infer_result = '0;
    model_clear();
    m_idx = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_zero("reset_state");

    // Incrementing pattern frame, 10-cycle gaps, result 7.
    w0 = n_we;
    send(SYNC, 10);
    for (int i = 0; i < PIX; i++) send(8'(i % 256), 10);
    chk("frame1_write_count", n_we - w0, PIX);
    do_tx(4'd7, 0, 8'h37, 0);

    // Junk before sync and a stray infer_done are ignored; 0xAA as pixel 5 is data.
    w0 = n_we;
    send(8'h55, 3);
    send(8'h00, 3);
    tick();
    infer_done   = 1'b1;
    infer_result = 4'd3;
    idle(5);
    chk("no_write_before_sync", n_we - w0, 0);
    send(SYNC, 2);
    for (int i = 0; i < PIX; i++) send((i == 5) ? SYNC : 8'($urandom), int'($urandom_range(2, 1)));
    do_tx(4'd2, 0, 8'h32, 0);

    // Result-to-ASCII table with varying transmitter backpressure.
    for (int v = 0; v < 6; v++) begin
      frame(1, 3);
      do_tx(vecs[v].res, vecs[v].hold, vecs[v].exp_b, 0);
    end

    // Inter-byte timeout aborts the frame; a gap one cycle short does not.
    s0 = n_start;
    send(SYNC, 1);
    for (int i = 0; i < 100; i++) send(8'($urandom), 1);
    idle(TMO + 5);
    chk("busy_after_timeout", busy, 0);
    chk("no_start_on_timeout", n_start - s0, 0);
    chk("frame_err_count", n_ferr, 1);
    send(SYNC, 1);
    for (int i = 0; i < PIX; i++) send(8'($urandom), (i == 50) ? TMO - 1 : 1);
    do_tx(4'd5, 0, 8'h35, 0);

    // Reset mid-load aborts the frame, following non-sync bytes are dropped.
    w0 = n_we;
    send(SYNC, 1);
    for (int i = 0; i < 300; i++) send(8'($urandom), 1);
    do_reset("reset_mid_load");
    for (int i = 0; i < 20; i++) send(8'(i), 2);
    chk("no_write_after_reset", n_we - w0, 300);
    frame(1, 2);
    do_tx(4'd4, 0, 8'h34, 1);
    idle(30);
    chk("busy_after_txh_reset", busy, 0);

    idle(5);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_starts", exp_start.size(), 0);
    chk("pending_frame_errs", exp_ferr.size(), 0);
    chk("pending_tx", exp_tx.size(), 0);
    chk("total_frame_errs", n_ferr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
